neuron_layer_sched: RTL

Controller that time-shares one `neuron_mac_simple` datapath across the NUM_NEURONS neurons of a fully-connected layer. It holds per-neuron weight rows and biases in a configurable register bank, accepts one input vector, issues one MAC job per neuron in index order, and collects each result into a layer output vector. It sits between the layer-input stream and the shared MAC, which it drives through the MAC's native in_valid/in_ready/out_valid ports.

---
 rtl/nn_pkg.sv | 18 +
 rtl/neuron_weight_bank.sv | 40 ++++
 rtl/neuron_layer_sched.sv | 116 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and default widths for the layer scheduler and the MAC it drives.
package nn_pkg;
    localparam int NUM_INPUTS_DEF = 8;
    localparam int X_W_DEF        = 8;
    localparam int W_W_DEF        = 8;
    localparam int B_W_DEF        = 16;
    localparam int OUT_W_DEF      = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} layer_state_t;

    // Index width, floored at one bit so a single-neuron layer still has a counter.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) w++;
        return (w < 1) ? 1 : w;
    endfunction
endpackage

// File: rtl/neuron_weight_bank.sv
// Per-neuron weight rows and biases: synchronous write, asynchronous read, cleared on reset.
module neuron_weight_bank
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
    parameter int W_W         = W_W_DEF,
    parameter int B_W         = B_W_DEF,
    parameter int NIDX_W      = clog2_min1(NUM_NEURONS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [NIDX_W-1:0]         waddr,
    input  logic [NUM_INPUTS*W_W-1:0] wrow,
    input  logic [B_W-1:0]            wbias,
    input  logic [NIDX_W-1:0]         raddr,
    output logic [NUM_INPUTS*W_W-1:0] rrow,
    output logic [B_W-1:0]            rbias
);
    logic [NUM_NEURONS-1:0][NUM_INPUTS*W_W-1:0] rows;
    logic [NUM_NEURONS-1:0][B_W-1:0]            biases;

    always_ff @(posedge clk) begin
        if (rst) begin
            rows   <= '0;
            biases <= '0;
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (we && waddr == NIDX_W'(i)) begin
                    rows[i]   <= wrow;
                    biases[i] <= wbias;
                end
            end
        end
    end

    assign rrow  = rows[raddr];
    assign rbias = biases[raddr];
endmodule

// File: rtl/neuron_layer_sched.sv
// Time-shares one MAC across all neurons of a fully-connected layer, one job per neuron in index order.
module neuron_layer_sched
    import nn_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int NUM_INPUTS  = NUM_INPUTS_DEF,
    parameter int X_W         = X_W_DEF,
    parameter int W_W         = W_W_DEF,
    parameter int B_W         = B_W_DEF,
    parameter int OUT_W       = OUT_W_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_we,
    input  logic [clog2_min1(NUM_NEURONS)-1:0]  cfg_addr,
    input  logic [NUM_INPUTS*W_W-1:0]           cfg_w_row,
    input  logic [B_W-1:0]                      cfg_bias,
    output logic                                cfg_err,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_INPUTS*X_W-1:0]           x_flat,
    output logic                                mac_in_valid,
    input  logic                                mac_in_ready,
    output logic [B_W-1:0]                      mac_bias,
    output logic [NUM_INPUTS*X_W-1:0]           mac_x_flat,
    output logic [NUM_INPUTS*W_W-1:0]           mac_w_flat,
    input  logic                                mac_out_valid,
    input  logic [OUT_W-1:0]                    mac_out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_NEURONS*OUT_W-1:0]        y_flat,
    output logic                                busy
);
    localparam int NIDX_W = clog2_min1(NUM_NEURONS);
    localparam logic [NIDX_W-1:0] LAST = NIDX_W'(NUM_NEURONS - 1);

    layer_state_t                         state;
    logic [NIDX_W-1:0]                    n;
    logic [NUM_INPUTS*X_W-1:0]            x_cap;
    logic [NUM_NEURONS-1:0][OUT_W-1:0]    y_reg;
    logic                                 addr_ok;
    logic                                 bank_we;

    assign addr_ok = int'(cfg_addr) < NUM_NEURONS;
    // Writes only land while idle, so a running job never sees its row change underneath it.
    assign bank_we = cfg_we && addr_ok && (state == IDLE);

    neuron_weight_bank #(
        .NUM_NEURONS(NUM_NEURONS),
        .NUM_INPUTS (NUM_INPUTS),
        .W_W        (W_W),
        .B_W        (B_W),
        .NIDX_W     (NIDX_W)
    ) u_bank (
        .clk  (clk),
        .rst  (rst),
        .we   (bank_we),
        .waddr(cfg_addr),
        .wrow (cfg_w_row),
        .wbias(cfg_bias),
        .raddr(n),
        .rrow (mac_w_flat),
        .rbias(mac_bias)
    );

    assign mac_x_flat = x_cap;
    assign y_flat     = y_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            n            <= '0;
            x_cap        <= '0;
            y_reg        <= '0;
            in_ready     <= 1'b1;
            mac_in_valid <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            cfg_err <= cfg_we && ((state != IDLE) || !addr_ok);
            case (state)
                IDLE: if (in_valid) begin
                    x_cap        <= x_flat;
                    n            <= '0;
                    state        <= ISSUE;
                    in_ready     <= 1'b0;
                    mac_in_valid <= 1'b1;
                    busy         <= 1'b1;
                end
                ISSUE: if (mac_in_ready) begin
                    state        <= WAIT;
                    mac_in_valid <= 1'b0;
                end
                WAIT: if (mac_out_valid) begin
                    y_reg[n] <= mac_out_data;
                    if (n == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        n            <= n + NIDX_W'(1);
                        state        <= ISSUE;
                        mac_in_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
